// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Debug tap indices and the saturating pending-count next-value function.
package regfile_pkg;

    localparam int REG_ZERO  = 0;
    localparam int REG_A0    = 10;
    localparam int REG_CAUSE = 15;

    // Pending count after one cycle: add a reservation, remove landed writes, floor at 0.
    function automatic int unsigned pend_next(int unsigned cur, logic inc, int unsigned dec);
        int unsigned up;
        up = cur + 32'(inc);
        return (dec >= up) ? 32'd0 : up - dec;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, write and reservation bus between issue/writeback (master) and the register file (slave).
interface regfile_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2
);
    logic [NUM_READ*ADDR_WIDTH-1:0]  raddr;
    logic [NUM_READ*DATA_WIDTH-1:0]  rdata;
    logic [NUM_READ-1:0]             rbusy;
    logic [NUM_WRITE-1:0]            wen;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr;
    logic [NUM_WRITE*DATA_WIDTH-1:0] wdata;
    logic                            rsv_valid;
    logic [ADDR_WIDTH-1:0]           rsv_addr;
    logic                            rsv_ready;
    logic [DATA_WIDTH-1:0]           halt_ret;
    logic [DATA_WIDTH-1:0]           cause;

    modport master (
        output raddr, wen, waddr, wdata, rsv_valid, rsv_addr,
        input  rdata, rbusy, rsv_ready, halt_ret, cause
    );

    modport slave (
        input  raddr, wen, waddr, wdata, rsv_valid, rsv_addr,
        output rdata, rbusy, rsv_ready, halt_ret, cause
    );
endinterface

// File: rtl/regfile_pend_ctr.sv
// One register's pending-write counter: +1 per reservation, -N per landed write, floor 0, one-cycle update.
// zero_o looks through same-cycle writes when REGFILE_BYPASS_EN is defined; full_o blocks further reservations.
module regfile_pend_ctr
    import regfile_pkg::*;
#(
    parameter int PEND_WIDTH = 2,
    parameter int DEC_WIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_i,
    input  logic [DEC_WIDTH-1:0] dec_i,
    output logic                 zero_o,
    output logic                 full_o
);
    logic [PEND_WIDTH-1:0] cnt_q, cnt_d;
    logic                  inc;

    assign full_o = &cnt_q;
    assign inc    = inc_i && !full_o;

    always_comb begin
        cnt_d = PEND_WIDTH'(pend_next(32'(cnt_q), inc, 32'(dec_i)));
    end

`ifdef REGFILE_BYPASS_EN
    assign zero_o = (32'(cnt_q) <= 32'(dec_i));
`else
    assign zero_o = (cnt_q == '0);
`endif

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register pending-write scoreboard; writes land next cycle, reads combinational.
// REGFILE_BYPASS_EN forwards same-cycle writes to read ports; no internal stalls, rsv_ready gates reservations.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int PEND_WIDTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    regfile_sb_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam int DEC_W = $clog2(NUM_WRITE + 1);

    logic [DATA_WIDTH-1:0] rf_q [NREGS];
    logic [DATA_WIDTH-1:0] rf_d [NREGS];
    logic [DEC_W-1:0]      dec_cnt [NREGS];
    logic                  pend_zero [NREGS];
    logic                  pend_full [NREGS];
    logic                  fire;
    logic [ADDR_WIDTH-1:0] wa;

    // Ascending port order makes the highest-index writer win on a collision.
    always_comb begin
        rf_d = rf_q;
        wa   = '0;
        for (int r = 0; r < NREGS; r++) dec_cnt[r] = '0;
        for (int i = 0; i < NUM_WRITE; i++) begin
            wa = bus.waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (bus.wen[i] && wa != ADDR_WIDTH'(REG_ZERO)) begin
                rf_d[wa]    = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
                dec_cnt[wa] = dec_cnt[wa] + DEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rf_q <= '{default: '0};
        else       rf_q <= rf_d;
    end

    assign bus.rsv_ready = (bus.rsv_addr == ADDR_WIDTH'(REG_ZERO)) || !pend_full[bus.rsv_addr];
    assign fire          = bus.rsv_valid && bus.rsv_ready;

    assign pend_zero[0] = 1'b1;
    assign pend_full[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_pend
        regfile_pend_ctr #(
            .PEND_WIDTH (PEND_WIDTH),
            .DEC_WIDTH  (DEC_W)
        ) u_ctr (
            .clk    (clk),
            .reset  (reset),
            .inc_i  (fire && (bus.rsv_addr == ADDR_WIDTH'(r))),
            .dec_i  (dec_cnt[r]),
            .zero_o (pend_zero[r]),
            .full_o (pend_full[r])
        );
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        ra        = '0;
        rd        = '0;
        bus.rdata = '0;
        bus.rbusy = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            ra = bus.raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd = rf_q[ra];
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < NUM_WRITE; i++) begin
                if (bus.wen[i] && bus.waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ra
                    && ra != ADDR_WIDTH'(REG_ZERO))
                    rd = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
`endif
            bus.rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd;
            bus.rbusy[k] = !pend_zero[ra];
        end
    end

    assign bus.halt_ret = rf_q[REG_A0];
    assign bus.cause    = rf_q[REG_CAUSE];
endmodule
